// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types and constants.
// fetch_entry_t is the {pc, inst} pair carried from imem to decode.
package rv32_pkg;

  localparam int XLEN         = 32;
  localparam int PC_STEP_WORD = 1;
  localparam int PC_STEP_BYTE = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, synchronous imem port and decode handshake.
// master = fetch unit side, slave = core/memory side.
interface rv32_fetch_unit_if #(
  parameter int XLEN   = rv32_pkg::XLEN,
  parameter int ADDR_W = 10
);
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [31:0]       out_inst;

  modport master (
    input  redirect_valid, redirect_pc,
    output imem_req, imem_addr,
    input  imem_rdata,
    output out_valid, out_pc, out_inst,
    input  out_ready
  );

  modport slave (
    output redirect_valid, redirect_pc,
    input  imem_req, imem_addr,
    output imem_rdata,
    input  out_valid, out_pc, out_inst,
    output out_ready
  );
endinterface

// File: rtl/rv32_sync_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count; DEPTH must be a power of two.
// Storage is cleared by srst so the head reads zero out of reset.
module rv32_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_s, push_ok_s, pop_ok_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign push_ok_s = push && !full_s;
  assign pop_ok_s  = pop && !empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next-state for storage, pointers and count; reset beats flush beats push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = {WIDTH{1'b0}};
      end
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    mem_q    <= mem_d;
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  rv32_sync_fifo_chk u_chk (
    .clk   (clk),
    .srst  (srst),
    .push  (push),
    .flush (flush),
    .full  (full_s)
  );

endmodule

// File: rtl/rv32_sync_fifo_chk.sv
// Protocol checker for rv32_sync_fifo: a push must never hit a full FIFO
// unless the same cycle flushes or resets it.
module rv32_sync_fifo_chk (
  input logic clk,
  input logic srst,
  input logic push,
  input logic flush,
  input logic full
);

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (srst) !(push && full && !flush)
  );

endmodule

// File: rtl/rv32_fetch_unit.sv
// RV32 fetch front end: PC generator, synchronous imem request stage and prefetch FIFO.
// Define RV32_FETCH_PERF_EN to add the perf_fetched / perf_killed counters.
module rv32_fetch_unit #(
  parameter int              XLEN     = rv32_pkg::XLEN,
  parameter int              ADDR_W   = 10,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
  parameter int              PC_STEP  = rv32_pkg::PC_STEP_WORD
) (
  input  logic                    clk,
  input  logic                    reset,
  rv32_fetch_unit_if.master       fif
`ifdef RV32_FETCH_PERF_EN
  ,
  output logic [31:0]             perf_fetched,
  output logic [31:0]             perf_killed
`endif
);
  import rv32_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;

  logic [XLEN-1:0] fpc_q, fpc_d, inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count_s;
  logic [OW-1:0]   occ_s;
  logic            fifo_empty_s, pop_req_s, issue_s, push_s, pop_s;
  fetch_entry_t    push_entry_s, head_entry_s;

  // Occupancy counts the in-flight slot and credits this cycle's pop, which keeps
  // a DEPTH-2 FIFO streaming at one instruction per cycle.
  always_comb begin
    pop_req_s     = !fifo_empty_s && fif.out_ready;
    occ_s         = {1'b0, count_s} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop_req_s};
    issue_s       = !reset && !fif.redirect_valid && (occ_s < OW'(DEPTH));
    fpc_d         = fpc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue_s;
    if (reset) begin
      fpc_d         = RESET_PC;
      inflight_pc_d = {XLEN{1'b0}};
      inflight_d    = 1'b0;
    end else if (fif.redirect_valid) begin
      fpc_d = fif.redirect_pc;
    end else if (issue_s) begin
      fpc_d         = fpc_q + XLEN'(PC_STEP);
      inflight_pc_d = fpc_q;
    end else begin
      fpc_d = fpc_q;
    end
  end

  // PC and in-flight request registers.
  always_ff @(posedge clk) begin
    fpc_q         <= fpc_d;
    inflight_q    <= inflight_d;
    inflight_pc_q <= inflight_pc_d;
  end

  // A response arriving in a redirect cycle belongs to the old path and is dropped.
  assign push_s            = inflight_q && !fif.redirect_valid;
  assign pop_s             = pop_req_s && !fif.redirect_valid;
  assign push_entry_s.pc   = inflight_pc_q;
  assign push_entry_s.inst = fif.imem_rdata;

  rv32_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .push  (push_s),
    .wdata (push_entry_s),
    .pop   (pop_s),
    .flush (fif.redirect_valid),
    .rdata (head_entry_s),
    .empty (fifo_empty_s),
    .count (count_s)
  );

  assign fif.imem_req  = issue_s;
  assign fif.out_valid = !fifo_empty_s;
  assign fif.out_pc    = head_entry_s.pc;
  assign fif.out_inst  = head_entry_s.inst;

  generate
    if (PC_STEP == PC_STEP_BYTE) begin : g_byte_addr
      assign fif.imem_addr = fpc_q[ADDR_W+1:2];
    end else begin : g_word_addr
      assign fif.imem_addr = fpc_q[ADDR_W-1:0];
    end
  endgenerate

`ifdef RV32_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_killed_q, perf_killed_d;

  // Killed = dropped response plus every valid entry discarded by the flush.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_killed_d  = perf_killed_q;
    if (reset) begin
      perf_fetched_d = 32'd0;
      perf_killed_d  = 32'd0;
    end else if (fif.redirect_valid) begin
      perf_killed_d = perf_killed_q + {31'd0, inflight_q} + 32'(count_s);
    end else begin
      perf_fetched_d = perf_fetched_q + {31'd0, push_s};
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    perf_fetched_q <= perf_fetched_d;
    perf_killed_q  <= perf_killed_d;
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_killed  = perf_killed_q;
`endif

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Self-checking bench for rv32_fetch_unit: three instances (word PC, wrapping PC, byte PC),
// imem returns addr + 0x100; a PC-stream reference model checks randomized traffic.
module tb_rv32_fetch_unit;
  import rv32_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  int   n_checks = 0;
  int   n_fail   = 0;

  rv32_fetch_unit_if #(.XLEN(32), .ADDR_W(10)) if0 ();
  rv32_fetch_unit_if #(.XLEN(32), .ADDR_W(10)) if1 ();
  rv32_fetch_unit_if #(.XLEN(32), .ADDR_W(10)) if2 ();

`ifdef RV32_FETCH_PERF_EN
  logic [31:0] pf0, pk0, pf1, pk1, pf2, pk2;
`endif

  rv32_fetch_unit #(.XLEN(32), .ADDR_W(10), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(1)) u0 (
    .clk(clk), .reset(rst0), .fif(if0)
`ifdef RV32_FETCH_PERF_EN
    , .perf_fetched(pf0), .perf_killed(pk0)
`endif
  );
  rv32_fetch_unit #(.XLEN(32), .ADDR_W(10), .DEPTH(4), .RESET_PC(32'h3FF), .PC_STEP(1)) u1 (
    .clk(clk), .reset(rst1), .fif(if1)
`ifdef RV32_FETCH_PERF_EN
    , .perf_fetched(pf1), .perf_killed(pk1)
`endif
  );
  rv32_fetch_unit #(.XLEN(32), .ADDR_W(10), .DEPTH(4), .RESET_PC(32'h10), .PC_STEP(4)) u2 (
    .clk(clk), .reset(rst2), .fif(if2)
`ifdef RV32_FETCH_PERF_EN
    , .perf_fetched(pf2), .perf_killed(pk2)
`endif
  );

  // Synchronous imem models: data one cycle after the request.
  always @(posedge clk) if (if0.imem_req) if0.imem_rdata <= {22'd0, if0.imem_addr} + 32'h100;
  always @(posedge clk) if (if1.imem_req) if1.imem_rdata <= {22'd0, if1.imem_addr} + 32'h100;
  always @(posedge clk) if (if2.imem_req) if2.imem_rdata <= {22'd0, if2.imem_addr} + 32'h100;

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_u0();
    next_cycle(); rst0 = 1'b1; if0.redirect_valid = 1'b0; if0.out_ready = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) next_cycle();
    #1;
    n_checks++; if (if0.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", if0.imem_req); end
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", if0.out_valid); end
    n_checks++; if (if0.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", if0.out_pc); end
    n_checks++; if (if0.out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", if0.out_inst); end
    n_checks++; if (if0.imem_addr !== 10'h000) begin n_fail++; $display("FAIL reset_addr0: got %h want 000", if0.imem_addr); end
    n_checks++; if (if1.imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL reset_addr1: got %h want 3ff", if1.imem_addr); end
    n_checks++; if (if2.imem_addr !== 10'h004) begin n_fail++; $display("FAIL reset_addr2: got %h want 004", if2.imem_addr); end
`ifdef RV32_FETCH_PERF_EN
    n_checks++; if (pf0 !== 32'd0 || pk0 !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d/%0d want 0/0", pf0, pk0); end
`endif
  endtask

  task automatic test_stream();
    next_cycle(); rst0 = 1'b0; if0.out_ready = 1'b1; #1;
    n_checks++; if (if0.imem_req !== 1'b1 || if0.imem_addr !== 10'h0) begin n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h want 1/000", if0.imem_req, if0.imem_addr); end
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid_c0: got %b want 0", if0.out_valid); end
    for (int i = 1; i <= 12; i++) begin
      next_cycle(); #1;
      n_checks++; if (if0.out_valid !== (i >= 2)) begin n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", i, if0.out_valid, (i >= 2)); end
      if (i >= 2) begin
        n_checks++; if (if0.out_pc !== 32'(i - 2) || if0.out_inst !== 32'(i - 2) + 32'h100) begin
          n_fail++; $display("FAIL stream_data c%0d: got pc=%h inst=%h want pc=%h inst=%h", i, if0.out_pc, if0.out_inst, 32'(i - 2), 32'(i - 2) + 32'h100);
        end
      end
    end
`ifdef RV32_FETCH_PERF_EN
    n_checks++; if (pf0 !== 32'd11) begin n_fail++; $display("FAIL stream_perf_fetched: got %0d want 11", pf0); end
`endif
  endtask

  task automatic test_backpressure();
    int reqs;
    logic [31:0] exp_pc;
    reqs = 0;
    reset_u0();
    rst0 = 1'b0; if0.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) next_cycle();
      #1;
      reqs += int'(if0.imem_req);
    end
    n_checks++; if (reqs != 4) begin n_fail++; $display("FAIL bp_issue_count: got %0d want 4", reqs); end
    n_checks++; if (if0.imem_req !== 1'b0 || if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stalled: got req=%b valid=%b want 0/1", if0.imem_req, if0.out_valid); end
    next_cycle(); if0.out_ready = 1'b1; #1;
    n_checks++; if (if0.imem_req !== 1'b1) begin n_fail++; $display("FAIL bp_req_on_pop: got %b want 1", if0.imem_req); end
    exp_pc = 32'h0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) begin next_cycle(); #1; end
      n_checks++; if (if0.out_valid !== 1'b1 || if0.out_pc !== exp_pc || if0.out_inst !== exp_pc + 32'h100) begin
        n_fail++; $display("FAIL bp_order %0d: got v=%b pc=%h inst=%h want pc=%h", j, if0.out_valid, if0.out_pc, if0.out_inst, exp_pc);
      end
      exp_pc = exp_pc + 32'd1;
    end
  endtask

  task automatic test_redirect();
    reset_u0();
    rst0 = 1'b0; if0.out_ready = 1'b0;
    repeat (4) next_cycle();
    if0.redirect_valid = 1'b1; if0.redirect_pc = 32'h40; #1;
    n_checks++; if (if0.imem_req !== 1'b0 || if0.out_pc !== 32'h0) begin n_fail++; $display("FAIL redir_cycle: got req=%b head=%h want 0/0", if0.imem_req, if0.out_pc); end
    next_cycle(); if0.redirect_valid = 1'b0; if0.out_ready = 1'b1; #1;
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_n1_valid: got %b want 0", if0.out_valid); end
    n_checks++; if (if0.imem_req !== 1'b1 || if0.imem_addr !== 10'h040) begin n_fail++; $display("FAIL redir_n1_req: got req=%b addr=%h want 1/040", if0.imem_req, if0.imem_addr); end
`ifdef RV32_FETCH_PERF_EN
    n_checks++; if (pk0 !== 32'd4) begin n_fail++; $display("FAIL redir_perf_killed: got %0d want 4", pk0); end
`endif
    next_cycle(); #1;
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_n2_valid: got %b want 0", if0.out_valid); end
    for (int k = 0; k < 3; k++) begin
      next_cycle(); #1;
      n_checks++; if (if0.out_valid !== 1'b1 || if0.out_pc !== 32'h40 + 32'(k) || if0.out_inst !== 32'h140 + 32'(k)) begin
        n_fail++; $display("FAIL redir_data %0d: got v=%b pc=%h inst=%h want pc=%h", k, if0.out_valid, if0.out_pc, if0.out_inst, 32'h40 + 32'(k));
      end
    end
  endtask

  task automatic test_reset_redirect();
    next_cycle(); rst0 = 1'b1; if0.redirect_valid = 1'b1; if0.redirect_pc = 32'h80; #1;
    n_checks++; if (if0.imem_req !== 1'b0) begin n_fail++; $display("FAIL rr_req: got %b want 0", if0.imem_req); end
    next_cycle(); rst0 = 1'b0; if0.redirect_valid = 1'b0; #1;
    n_checks++; if (if0.imem_req !== 1'b1 || if0.imem_addr !== 10'h000 || if0.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rr_restart: got req=%b addr=%h v=%b want 1/000/0", if0.imem_req, if0.imem_addr, if0.out_valid);
    end
    next_cycle(); #1;
    n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_valid_c1: got %b want 0", if0.out_valid); end
    next_cycle(); #1;
    n_checks++; if (if0.out_valid !== 1'b1 || if0.out_pc !== 32'h0) begin n_fail++; $display("FAIL rr_first: got v=%b pc=%h want 1/0", if0.out_valid, if0.out_pc); end
  endtask

  task automatic test_wrap();
    next_cycle(); rst1 = 1'b0; if1.out_ready = 1'b1; #1;
    n_checks++; if (if1.imem_req !== 1'b1 || if1.imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL wrap_addr0: got req=%b addr=%h want 1/3ff", if1.imem_req, if1.imem_addr); end
    next_cycle(); #1;
    n_checks++; if (if1.imem_addr !== 10'h000) begin n_fail++; $display("FAIL wrap_addr1: got %h want 000", if1.imem_addr); end
    next_cycle(); #1;
    n_checks++; if (if1.out_pc !== 32'h3FF || if1.out_inst !== 32'h4FF) begin n_fail++; $display("FAIL wrap_out0: got pc=%h inst=%h want 3ff/4ff", if1.out_pc, if1.out_inst); end
    next_cycle(); #1;
    n_checks++; if (if1.out_pc !== 32'h400 || if1.out_inst !== 32'h100) begin n_fail++; $display("FAIL wrap_out1: got pc=%h inst=%h want 400/100", if1.out_pc, if1.out_inst); end
  endtask

  task automatic test_step4();
    logic [9:0]  exp_addr [3];
    logic [31:0] exp_pc   [3];
    exp_addr[0] = 10'd4;   exp_addr[1] = 10'd5;   exp_addr[2] = 10'd6;
    exp_pc[0]   = 32'h10;  exp_pc[1]   = 32'h14;  exp_pc[2]   = 32'h18;
    next_cycle(); rst2 = 1'b0; if2.out_ready = 1'b1; #1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin next_cycle(); #1; end
      if (c < 3) begin
        n_checks++; if (if2.imem_addr !== exp_addr[c]) begin n_fail++; $display("FAIL step4_addr c%0d: got %h want %h", c, if2.imem_addr, exp_addr[c]); end
      end
      if (c >= 2) begin
        n_checks++; if (if2.out_valid !== 1'b1 || if2.out_pc !== exp_pc[c-2] || if2.out_inst !== {22'd0, exp_addr[c-2]} + 32'h100) begin
          n_fail++; $display("FAIL step4_out c%0d: got v=%b pc=%h inst=%h want pc=%h", c, if2.out_valid, if2.out_pc, if2.out_inst, exp_pc[c-2]);
        end
      end
    end
  endtask

  // Reference model: the delivered stream is consecutive PCs from the last restart point.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic        redir;
    logic [31:0] rpc;
    int          age;
    reset_u0();
    rst0 = 1'b0;
    exp_pc = 32'h0;
    age = 100;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) next_cycle();
      redir = ($urandom_range(0, 19) == 0);
      rpc   = 32'($urandom_range(0, 4095));
      if0.redirect_valid = redir;
      if0.redirect_pc    = rpc;
      if0.out_ready      = redir ? 1'b0 : ($urandom_range(0, 9) < 7);
      #1;
      age = (age < 100) ? age + 1 : age;
      if (age == 1 || age == 2) begin
        n_checks++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush_gap n=%0d: got v=%b want 0", n, if0.out_valid); end
      end
      if (age == 3) begin
        n_checks++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_refill n=%0d: got v=%b want 1", n, if0.out_valid); end
      end
      if (redir) begin
        n_checks++; if (if0.imem_req !== 1'b0) begin n_fail++; $display("FAIL rnd_redir_req n=%0d: got %b want 0", n, if0.imem_req); end
        exp_pc = rpc;
        age = 0;
      end else if (if0.out_valid === 1'b1 && if0.out_ready === 1'b1) begin
        n_checks++; if (if0.out_pc !== exp_pc || if0.out_inst !== {22'd0, exp_pc[9:0]} + 32'h100) begin
          n_fail++; $display("FAIL rnd_data n=%0d: got pc=%h inst=%h want pc=%h inst=%h", n, if0.out_pc, if0.out_inst, exp_pc, {22'd0, exp_pc[9:0]} + 32'h100);
        end
        exp_pc = exp_pc + 32'd1;
      end else begin
        exp_pc = exp_pc;
      end
    end
    if0.redirect_valid = 1'b0;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.redirect_valid = 1'b0; if0.redirect_pc = 32'h0; if0.out_ready = 1'b1;
    if1.redirect_valid = 1'b0; if1.redirect_pc = 32'h0; if1.out_ready = 1'b1;
    if2.redirect_valid = 1'b0; if2.redirect_pc = 32'h0; if2.out_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_reset_redirect();
    test_wrap();
    test_step4();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_fetch_unit.md
# rv32_fetch_unit

Parametrised instruction-fetch front end for the next-generation pipelined RV32 core. It replaces the bare PC register + PC+1 increment with a PC generator, a synchronous-imem request stage and a DEPTH-entry prefetch FIFO. It delivers {pc, inst} pairs to decode over a valid/ready handshake, and a single-cycle redirect from execute flushes everything in flight.

## Interface
- XLEN, 32, PC and out_pc width
- ADDR_W, 10, imem word-address width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 0, fetch PC after reset
- PC_STEP, 1, PC increment: 1 = word-addressed PC (current core convention); 4 = byte-addressed PC
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch PC
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  word address: fpc[ADDR_W-1:0] if PC_STEP=1, fpc[ADDR_W+1:2] if PC_STEP=4
- imem_rdata  in  32  instruction; valid exactly one cycle after an imem_req cycle
- out_valid  out  1  FIFO head valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head
- out_inst  out  32  instruction at head
- perf_fetched, perf_killed  out  32 each  only with RV32_FETCH_PERF_EN

## Operation
- State: fpc (XLEN), inflight bit + inflight_pc, FIFO of {pc, inst}, count (clog2(DEPTH)+1 bits).
- Issue: imem_req = !reset && !redirect_valid && (count + inflight − pop < DEPTH), where pop = out_valid && out_ready. On issue: fpc ← fpc + PC_STEP (mod 2^XLEN), inflight ← 1, inflight_pc ← fpc; otherwise inflight ← 0.
- Response: cycle after issue, {inflight_pc, imem_rdata} is pushed unless killed. No full-FIFO drop is possible by construction; pushing into a full FIFO is an assertion failure.
- FIFO: push and pop in the same cycle are both honoured. Head outputs hold stable while out_valid && !out_ready.
- Redirect (priority over all but reset): fpc ← redirect_pc, FIFO emptied, pending response killed, imem_req = 0 that cycle. A pop in the same cycle is void. Decode must not consume the head in a redirect cycle.
- Reset: fpc ← RESET_PC, FIFO storage and pointers cleared, inflight ← 0, perf counters ← 0. Reset beats a simultaneous redirect.
- out_pc keeps full XLEN. imem_addr truncates, so imem wraps at 2^ADDR_W words while out_pc keeps counting.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC slice, out_valid 0, out_pc 0, out_inst 0, perf 0.
- Fetch latency: req in cycle C → entry pushed end of C+1 → out_valid in C+2. First req is in the first cycle after reset deasserts.
- Redirect in cycle N: out_valid 0 in N+1, req for redirect_pc in N+1, out_pc = redirect_pc valid in N+3.
- Sustained throughput 1 instr/cycle with out_ready held high, for every DEPTH ≥ 2 (pop credit). There is a combinational path from out_ready to imem_req.
- out_ready low: after DEPTH outstanding fetches, imem_req stays 0 until a pop.

## Configuration
- RV32_FETCH_PERF_EN defined:
  - perf_fetched counts responses pushed.
  - perf_killed counts responses killed plus valid FIFO entries flushed by redirect.
  - Both are 32-bit, wrap modulo 2^32, and clear on reset.
- Undefined: counters and both ports are absent.

## Structure
- rv32_pkg holds:
  - XLEN default
  - PC_STEP_WORD=1 and PC_STEP_BYTE=4 constants
  - fetch_entry_t packed struct {pc, inst}
- One sub-module, rv32_sync_fifo: parametrised on entry type/width and DEPTH, with push/pop/flush, count output and synchronous reset.
- PC/issue logic stays in rv32_fetch_unit.

## Test plan
- Streaming: reset release, out_ready=1, model returns rdata = addr + 0x100. First out_valid 2 cycles after the first req, then every cycle: out_pc 0,1,2,…; out_inst 0x100,0x101,….
- Back-pressure, DEPTH=4: out_ready=0 for 10 cycles. imem_req drops after 4 issues, count=4. On release, outputs are in order with no gaps or duplicates, and imem_req restarts in the same cycle as the first pop.
- Redirect to 0x40 with 3 FIFO entries and 1 in flight. Next cycle out_valid=0. Next delivered out_pc=0x40, 3 cycles after redirect. Stale PCs are never seen. With RV32_FETCH_PERF_EN, perf_killed=4.
- Reset and redirect_valid in the same cycle: fetch restarts at RESET_PC and out_valid stays 0 for 2 cycles.
- Wrap, ADDR_W=10, RESET_PC=0x3FF, PC_STEP=1: imem_addr 0x3FF then 0x000, while out_pc reads 0x3FF then 0x400.
- PC_STEP=4, RESET_PC=0x10: imem_addr 4,5,6 and out_pc 0x10,0x14,0x18.
